// File: rtl/ifu_param.sv
//==============================================================================
// Module   : ifu_param
// Purpose  : Instruction fetch unit for a single-cycle MIPS-style datapath.
//            Holds the byte PC and selects the next PC from sequential,
//            branch, J-type jump or jump-register sources, with stall,
//            a registered pc_valid and a sticky misalignment flag.
// Options  : IFU_RAS_EN - adds a circular return-address stack (call/ret).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifu_param #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic [15:0]           i_imm16,
  input  logic                  i_jump,
  input  logic [25:0]           i_target_instr,
  input  logic                  i_jr,
  input  logic [ADDR_WIDTH-1:0] i_jr_target,
  input  logic                  i_call,
  input  logic                  i_ret,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-3:0] o_pc_word,
  output logic [ADDR_WIDTH-1:0] o_link_addr,
  output logic                  o_pc_valid,
  output logic                  o_misalign_err,
  output logic                  o_ras_empty,
  output logic                  o_ras_overflow
);

  localparam logic [ADDR_WIDTH-1:0] c_FOUR = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_pc_valid;
  logic                  r_misalign;

  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_branch_target;
  logic [ADDR_WIDTH-1:0] w_jump_target;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_adv;
  logic                  w_misalign;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ret_take;
  logic                  w_call_ok;
  logic [ADDR_WIDTH-1:0] w_ras_pop_val;

  // Only a valid, unstalled PC advances; the first edge after reset only raises valid.
  assign w_adv           = r_pc_valid & ~i_stall;
  assign w_pc_plus4      = r_pc + c_FOUR;
  assign w_branch_target = w_pc_plus4 + ADDR_WIDTH'({{18{i_imm16[15]}}, i_imm16, 2'b00});

  // J-type target keeps the pc+4 region bits only when the PC is wider than 28 bits.
  generate
    if (ADDR_WIDTH > 28) begin : g_jump_wide
      assign w_jump_target = {w_pc_plus4[ADDR_WIDTH-1:28], i_target_instr, 2'b00};
    end else begin : g_jump_narrow
      assign w_jump_target = ADDR_WIDTH'({i_target_instr, 2'b00});
    end
  endgenerate

  // Next-PC priority select: ret > jr > jump > branch > sequential.
  always_comb begin
    w_pc_next  = w_pc_plus4;
    w_misalign = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    if (w_ret_take) begin
      w_pc_next = w_ras_pop_val;
      w_pop     = 1'b1;
    end else if (i_jr) begin
      w_pc_next  = {i_jr_target[ADDR_WIDTH-1:2], 2'b00};
      w_misalign = |i_jr_target[1:0];
    end else if (i_jump) begin
      w_pc_next = w_jump_target;
      w_push    = w_call_ok;
    end else if (i_branch) begin
      w_pc_next = w_branch_target;
    end
  end

  // PC, valid and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else if (!r_pc_valid) begin
      r_pc_valid <= 1'b1;
    end else if (!i_stall) begin
      r_pc <= w_pc_next;
      if (w_misalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

`ifdef IFU_RAS_EN
  localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_ras_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0]    r_ras_top;   // next slot to write
  logic [c_CNT_W-1:0]    r_ras_cnt;
  logic                  r_ras_ovf;
  logic [c_PTR_W-1:0]    w_top_m1;
  logic                  w_ras_full;

  assign w_top_m1      = r_ras_top - c_PTR_W'(1);
  assign w_ras_full    = (r_ras_cnt == c_CNT_W'(RAS_DEPTH));
  assign w_ras_pop_val = r_ras_mem[w_top_m1];
  // An empty stack lets ret fall through to the lower-priority sources.
  assign w_ret_take    = i_ret & (r_ras_cnt != '0);
  assign w_call_ok     = i_call;

  // Stack storage: a push on a full stack overwrites the oldest slot naturally.
  always_ff @(posedge clk) begin
    if (rst_n && w_adv && w_push) begin
      r_ras_mem[r_ras_top] <= w_pc_plus4;
    end
  end

  // Stack pointer, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ras_top <= '0;
      r_ras_cnt <= '0;
      r_ras_ovf <= 1'b0;
    end else if (w_adv) begin
      if (w_pop) begin
        r_ras_top <= w_top_m1;
        r_ras_cnt <= r_ras_cnt - c_CNT_W'(1);
      end else if (w_push) begin
        r_ras_top <= r_ras_top + c_PTR_W'(1);
        if (w_ras_full) begin
          r_ras_ovf <= 1'b1;
        end else begin
          r_ras_cnt <= r_ras_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  assign o_ras_empty    = (r_ras_cnt == '0);
  assign o_ras_overflow = r_ras_ovf;
`else
  assign w_ret_take     = 1'b0;
  assign w_call_ok      = 1'b0;
  assign w_ras_pop_val  = '0;
  assign o_ras_empty    = 1'b1;
  assign o_ras_overflow = 1'b0;

  logic w_unused_ras;
  assign w_unused_ras = ^{i_call, i_ret, w_push, w_pop};
`endif

  assign o_pc           = r_pc;
  assign o_pc_word      = r_pc[ADDR_WIDTH-1:2];
  assign o_link_addr    = w_pc_plus4;
  assign o_pc_valid     = r_pc_valid;
  assign o_misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_ifu_param.sv
//==============================================================================
// Module   : tb_ifu_param
// Purpose  : Self-checking bench for ifu_param (ADDR_WIDTH=32, RESET_VECTOR=0,
//            RAS_DEPTH=4). Directed scenarios followed by random stimulus,
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ifu_param;

`ifdef IFU_RAS_EN
  localparam bit c_RAS_ON = 1'b1;
`else
  localparam bit c_RAS_ON = 1'b0;
`endif
  localparam int c_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, jump, jr, call, ret;
  logic [15:0] imm16;
  logic [25:0] target_instr;
  logic [31:0] jr_target;
  logic [31:0] pc, link_addr;
  logic [29:0] pc_word;
  logic        pc_valid, misalign_err, ras_empty, ras_overflow;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_valid, m_mis, m_ovf;
  logic [31:0] m_ras[$];

  ifu_param #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(c_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_branch(branch), .i_imm16(imm16),
    .i_jump(jump), .i_target_instr(target_instr), .i_jr(jr), .i_jr_target(jr_target),
    .i_call(call), .i_ret(ret), .o_pc(pc), .o_pc_word(pc_word), .o_link_addr(link_addr),
    .o_pc_valid(pc_valid), .o_misalign_err(misalign_err), .o_ras_empty(ras_empty),
    .o_ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
    call = 1'b0; ret = 1'b0; imm16 = '0; target_instr = '0; jr_target = '0;
  endtask

  // Advance the reference model by one clock edge from the current inputs.
  task automatic model_edge();
    logic [31:0] p4;
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 0; m_mis = 0; m_ovf = 0; m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (!stall) begin
      p4 = m_pc + 32'd4;
      if (c_RAS_ON && ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else if (jr) begin
        m_pc = jr_target & ~32'd3;
        if (jr_target % 4 != 0) m_mis = 1;
      end else if (jump) begin
        m_pc = (p4 & 32'hF000_0000) | (32'(target_instr) * 4);
        if (c_RAS_ON && call) begin
          if (m_ras.size() == c_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_ras.push_back(p4);
        end
      end else if (branch) begin
        m_pc = p4 + 32'($signed(imm16)) * 4;
      end else begin
        m_pc = p4;
      end
    end
  endtask

  // One clock: update model, step DUT, then compare every output.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_word", {2'b00, pc_word}, {2'b00, m_pc[31:2]});
    chk("link_addr", link_addr, m_pc + 32'd4);
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("ras_empty", {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
    chk("ras_overflow", {31'b0, ras_overflow}, {31'b0, m_ovf});
  endtask

  initial begin
    m_pc = 32'h0; m_valid = 0; m_mis = 0; m_ovf = 0;
    idle_inputs();

    // Reset for two edges, release, eleven idle edges
    rst_n = 1'b0; jump = 1'b1; target_instr = 26'h3FF;
    tick(); tick();
    idle_inputs();
    tick();
    chk("valid_after_first_edge", {31'b0, pc_valid}, 32'd1);
    chk("pc_after_first_edge", pc, 32'h0);
    repeat (10) tick();
    chk("pc_after_idle", pc, 32'h28);

    // Jump and branches
    jump = 1'b1; target_instr = 26'hC; tick(); idle_inputs();
    chk("jump_target", pc, 32'h30);
    branch = 1'b1; imm16 = 16'd3; tick();
    chk("branch_fwd", pc, 32'h40);
    imm16 = 16'hFFFE; tick(); idle_inputs();
    chk("branch_back", pc, 32'h3C);

    // Stall holds; jump beats branch
    stall = 1'b1; jump = 1'b1; branch = 1'b1; target_instr = 26'h20; imm16 = 16'd5;
    tick(); tick();
    chk("stall_hold", pc, 32'h3C);
    stall = 1'b0; tick(); idle_inputs();
    chk("jump_over_branch", pc, 32'h80);

    // Misaligned jr sets sticky flag
    jr = 1'b1; jr_target = 32'h103; tick(); idle_inputs();
    chk("jr_aligned", pc, 32'h100);
    chk("misalign_set", {31'b0, misalign_err}, 32'd1);
    repeat (3) tick();
    chk("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // Wrap-around at the top of the address space
    jr = 1'b1; jr_target = 32'hFFFF_FFFC; tick(); idle_inputs();
    tick();
    chk("pc_wrap", pc, 32'h0);

    // Reset clears flags; five calls then five returns
    rst_n = 1'b0; tick(); idle_inputs(); tick();
    chk("misalign_cleared", {31'b0, misalign_err}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      jump = 1'b1; call = 1'b1; target_instr = 26'(k * 64); tick();
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      ret = 1'b1; tick();
    end
    idle_inputs();
`ifdef IFU_RAS_EN
    chk("ras_fifth_ret_seq", pc, 32'h108);
    chk("ras_overflow_set", {31'b0, ras_overflow}, 32'd1);
    chk("ras_empty_after_rets", {31'b0, ras_empty}, 32'd1);
`else
    chk("no_ras_ret_seq", pc, 32'h504 + 32'd16);
`endif

    // Fill the stack, then reset mid-jump
    for (int k = 1; k <= 5; k++) begin
      jump = 1'b1; call = 1'b1; target_instr = 26'(k * 16); tick();
    end
    rst_n = 1'b0; jump = 1'b1; call = 1'b1; tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_ras_empty", {31'b0, ras_empty}, 32'd1);
    chk("reset_ovf", {31'b0, ras_overflow}, 32'd0);
    idle_inputs();
    tick();

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      rst_n        = ($urandom_range(0, 99) >= 2);
      stall        = ($urandom_range(0, 9) == 0);
      branch       = $urandom_range(0, 1);
      imm16        = 16'($urandom);
      jump         = ($urandom_range(0, 3) == 0);
      target_instr = 26'($urandom);
      jr           = ($urandom_range(0, 7) == 0);
      jr_target    = $urandom;
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
      call         = $urandom_range(0, 1);
      ret          = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
